// File: rtl/pulse_burst_gen.sv
// Runtime-programmable OE pulse-burst generator driven by a clock-enable prescaler.
// Optional macro PULSE_BURST_WIDTH_EN adds the PW port and multi-cycle OE pulses.
module pulse_burst_gen #(
  parameter int DIV_W    = 16,
  parameter int PERIOD_W = 4,
  parameter int COUNT_W  = 3,
  parameter int PW_W     = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                START,
  input  logic                ABORT,
  input  logic                CONT,
  input  logic [DIV_W-1:0]    DIV,
  input  logic [PERIOD_W-1:0] PERIOD,
  input  logic [COUNT_W-1:0]  BURST,
`ifdef PULSE_BURST_WIDTH_EN
  input  logic [PW_W-1:0]     PW,
`endif
  output logic                OE,
  output logic                BUSY,
  output logic                DONE,
  output logic [COUNT_W-1:0]  PULSE_IDX
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;

  state_t              state;
  logic [DIV_W-1:0]    div_q;
  logic [DIV_W-1:0]    pre_cnt;
  logic [PERIOD_W-1:0] per_q;
  logic [PERIOD_W-1:0] tick_cnt;
  logic [COUNT_W-1:0]  burst_q;
  logic                cont_q;
  logic                due;
  logic [PW_W-1:0]     wcnt;
  logic [PW_W-1:0]     pw_q;

  function automatic logic [PERIOD_W-1:0] sat_period(input logic [PERIOD_W-1:0] v);
    return (v == '0) ? PERIOD_W'(1) : v;
  endfunction

`ifdef PULSE_BURST_WIDTH_EN
  function automatic logic [PW_W-1:0] sat_width(input logic [PW_W-1:0] v);
    return (v == '0) ? PW_W'(1) : v;
  endfunction
`else
  assign pw_q = PW_W'(1);
`endif

  logic               tick;
  logic               period_end;
  logic [COUNT_W:0]   pending;
  logic               pulse_room;
  logic               finish_now;

  // A pulse already flagged as due counts toward the burst, so back-to-back
  // periods cannot overshoot BURST.
  always_comb begin
    tick       = (pre_cnt == div_q);
    period_end = tick && (tick_cnt == per_q - PERIOD_W'(1));
    pending    = {1'b0, PULSE_IDX} + {{COUNT_W{1'b0}}, due};
    pulse_room = cont_q || (pending != {1'b0, burst_q});
    finish_now = !cont_q && !due && (PULSE_IDX == burst_q) && (!OE || (wcnt == '0));
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= S_IDLE;
      OE        <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      PULSE_IDX <= '0;
      div_q     <= '0;
      pre_cnt   <= '0;
      per_q     <= '0;
      tick_cnt  <= '0;
      burst_q   <= '0;
      cont_q    <= 1'b0;
      due       <= 1'b0;
      wcnt      <= '0;
`ifdef PULSE_BURST_WIDTH_EN
      pw_q      <= '0;
`endif
    end else if (ABORT) begin
      state <= S_IDLE;
      OE    <= 1'b0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
      due   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          DONE <= 1'b0;
          if (START) begin
            div_q     <= DIV;
            per_q     <= sat_period(PERIOD);
            burst_q   <= BURST;
            cont_q    <= CONT;
`ifdef PULSE_BURST_WIDTH_EN
            pw_q      <= sat_width(PW);
`endif
            pre_cnt   <= '0;
            tick_cnt  <= '0;
            PULSE_IDX <= '0;
            due       <= 1'b0;
            wcnt      <= '0;
            BUSY      <= 1'b1;
            state     <= S_RUN;
          end
        end
        S_RUN: begin
          pre_cnt <= tick ? '0 : pre_cnt + DIV_W'(1);
          if (tick)
            tick_cnt <= period_end ? '0 : tick_cnt + PERIOD_W'(1);
          due <= period_end && pulse_room;
          // A due pulse (re)starts the OE window even if OE is still high.
          if (due) begin
            OE        <= 1'b1;
            wcnt      <= pw_q - PW_W'(1);
            PULSE_IDX <= PULSE_IDX + COUNT_W'(1);
          end else if (OE) begin
            if (wcnt == '0)
              OE <= 1'b0;
            else
              wcnt <= wcnt - PW_W'(1);
          end
          if (finish_now) begin
            OE    <= 1'b0;
            DONE  <= 1'b1;
            state <= S_FINISH;
          end
        end
        S_FINISH: begin
          DONE  <= 1'b0;
          BUSY  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
